// File: rtl/data_memory_m.sv
// data_memory_m: synchronous MEM-stage data memory.
// Supports byte, halfword and word loads and stores, with sign or zero
// extension on sub-word loads. Every load has a fixed one-cycle latency, and
// the registered result feeds the MemToReg writeback mux.
//
// Request/response handshake:
//   - A request (memRead or memWrite) is accepted on any rising edge where
//     busy=0. While busy=1, requests are ignored and not queued, so
//     upstream must hold or re-issue them.
//   - A store completes at its accepting edge and never raises busy.
//   - An accepted load (memRead=1, memWrite=0) makes busy=1 and
//     readValid=1 for exactly the next cycle. readData is valid only while
//     readValid=1 and holds its value afterwards.
//   - An illegal or misaligned access pulses misaligned in the following
//     cycle. An illegal load still produces readValid, with readData=0.
//
// The FSM state is the enum signal 'state'; bind checkers to it directly.
module data_memory_m #(
  parameter int DEPTH_WORDS = 256,
  parameter int INDEX_WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               memRead,
  input  logic               memWrite,
  input  logic [1:0]         size,
  input  logic               loadUnsigned,
  input  logic [31:0]        address,
  input  logic signed [31:0] writeData,
  output logic signed [31:0] readData,
  output logic               readValid,
  output logic               busy,
  output logic               misaligned
);

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  logic [31:0] mem [DEPTH_WORDS];

  logic [INDEX_WIDTH-1:0] word_idx;
  logic [1:0]             byte_off;
  logic                   illegal;
  logic                   load_req;
  logic                   store_en;
  logic [31:0]            rd_word;
  logic [7:0]             byte_lane;
  logic [15:0]            half_lane;
  logic [31:0]            load_val;
  logic [3:0]             wr_be;
  logic [31:0]            wr_data;

  // Address bits above the word index are ignored, so accesses wrap
  // modulo the array size.
  logic unused_addr_bits;
  assign unused_addr_bits = ^address[31:INDEX_WIDTH+2];

  assign word_idx = address[INDEX_WIDTH+1:2];
  assign byte_off = address[1:0];
  assign rd_word  = mem[word_idx];

  // Requests are only examined in IDLE. A store takes priority over a load.
  assign load_req = (state == IDLE) && memRead && !memWrite;
  assign store_en = (state == IDLE) && memWrite && !illegal && !reset;

  // Flag illegal sizes and accesses that are not naturally aligned.
  always_comb begin
    illegal = 1'b0;
    case (size)
      2'b00:   illegal = 1'b0;
      2'b01:   illegal = byte_off[0];
      2'b10:   illegal = (byte_off != 2'b00);
      default: illegal = 1'b1;
    endcase
  end

  // Extract the addressed little-endian lane and sign- or zero-extend it.
  always_comb begin
    byte_lane = rd_word[{byte_off, 3'b000} +: 8];
    half_lane = byte_off[1] ? rd_word[31:16] : rd_word[15:0];
    load_val  = rd_word;
    case (size)
      2'b00:   load_val = {{24{~loadUnsigned & byte_lane[7]}}, byte_lane};
      2'b01:   load_val = {{16{~loadUnsigned & half_lane[15]}}, half_lane};
      default: load_val = rd_word;
    endcase
  end

  // Build byte enables and the store data. Sub-word data is replicated
  // across the word so each enabled lane already holds the correct bits.
  always_comb begin
    wr_be   = 4'b0000;
    wr_data = writeData;
    case (size)
      2'b00: begin
        wr_be   = 4'b0001 << byte_off;
        wr_data = {4{writeData[7:0]}};
      end
      2'b01: begin
        wr_be   = byte_off[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{writeData[15:0]}};
      end
      2'b10: begin
        wr_be   = 4'b1111;
        wr_data = writeData;
      end
      default: begin
        wr_be   = 4'b0000;
        wr_data = writeData;
      end
    endcase
  end

  // Array write port. The contents are intentionally not cleared by reset.
  always_ff @(posedge clk) begin
    if (store_en) begin
      for (int k = 0; k < 4; k++) begin
        if (wr_be[k]) begin
          mem[word_idx][8*k +: 8] <= wr_data[8*k +: 8];
        end
      end
    end
  end

  // Next-state and handshake outputs. readValid in RESP is gated by reset.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    readValid  = 1'b0;
    case (state)
      IDLE: begin
        if (load_req) begin
          state_next = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
        busy       = 1'b1;
        readValid  = !reset;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register, registered load result and one-cycle misaligned pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      readData   <= '0;
      misaligned <= 1'b0;
    end else begin
      state      <= state_next;
      misaligned <= (state == IDLE) && (memRead || memWrite) && illegal;
      if (load_req) begin
        readData <= illegal ? 32'sd0 : $signed(load_val);
      end
    end
  end

endmodule

// File: tb/tb_data_memory_m.sv
// tb_data_memory_m: directed and random checks for data_memory_m.
// Uses a byte-addressed reference model of the array and a queue of
// expected load results.
module tb_data_memory_m;

  logic               clk;
  logic               reset;
  logic               memRead;
  logic               memWrite;
  logic [1:0]         size;
  logic               loadUnsigned;
  logic [31:0]        address;
  logic signed [31:0] writeData;
  logic signed [31:0] readData;
  logic               readValid;
  logic               busy;
  logic               misaligned;

  int n_cmp;
  int n_err;

  // Each entry packs {expected misaligned, expected readData}.
  logic [32:0] exp_q[$];

  // Byte-wide reference image: 256 words = 1024 bytes.
  logic [7:0] model_mem [1024];

  data_memory_m #(.DEPTH_WORDS(256), .INDEX_WIDTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .memRead      (memRead),
    .memWrite     (memWrite),
    .size         (size),
    .loadUnsigned (loadUnsigned),
    .address      (address),
    .writeData    (writeData),
    .readData     (readData),
    .readValid    (readValid),
    .busy         (busy),
    .misaligned   (misaligned)
  );

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog in case anything stalls outside the bounded waits.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Advance to just after the next rising edge. Inputs are driven and
  // outputs sampled here, away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic is_illegal(input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'b11) return 1'b1;
    if (sz == 2'b01) return a[0];
    if (sz == 2'b10) return a[1:0] != 2'b00;
    return 1'b0;
  endfunction

  function automatic logic [32:0] model_load(input logic [31:0] a, input logic [1:0] sz,
                                             input logic uns);
    int base;
    logic [7:0]  b;
    logic [15:0] h;
    base = int'(a[9:0]);
    if (is_illegal(a, sz)) return {1'b1, 32'h0};
    if (sz == 2'b00) begin
      b = model_mem[base];
      return {1'b0, (uns ? 24'h0 : {24{b[7]}}), b};
    end
    if (sz == 2'b01) begin
      h = {model_mem[base+1], model_mem[base]};
      return {1'b0, (uns ? 16'h0 : {16{h[15]}}), h};
    end
    return {1'b0, model_mem[base+3], model_mem[base+2], model_mem[base+1], model_mem[base]};
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    int base;
    int nb;
    base = int'(a[9:0]);
    nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    if (!is_illegal(a, sz)) begin
      for (int k = 0; k < nb; k++) model_mem[base+k] = d[8*k +: 8];
    end
  endtask

  // Drive one store for a single cycle. Afterwards we are in the cycle
  // where misaligned reflects this store.
  task automatic drive_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    memWrite  = 1'b1;
    memRead   = 1'b0;
    size      = sz;
    address   = a;
    writeData = d;
    model_store(a, sz, d);
    tick();
    memWrite  = 1'b0;
  endtask

  // Issue a load, push its expected result, wait a bounded time for
  // readValid, and pop the expectation. act = {late, misaligned, readData},
  // where late is set if the response did not arrive in the next cycle.
  task automatic run_load(input logic [31:0] a, input logic [1:0] sz, input logic uns,
                          input logic [32:0] expv,
                          output logic [33:0] act, output logic [32:0] want);
    int waited;
    bit got;
    memRead      = 1'b1;
    memWrite     = 1'b0;
    size         = sz;
    loadUnsigned = uns;
    address      = a;
    exp_q.push_back(expv);
    tick();
    memRead = 1'b0;
    got     = 1'b0;
    waited  = 0;
    act     = {1'b1, 33'h0};
    while (!got && waited < 4) begin
      if (readValid === 1'b1) begin
        got = 1'b1;
        act = {(waited != 0), misaligned, readData};
      end else begin
        tick();
        waited++;
      end
    end
    want = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h1_DEADBEEF;
    if (got) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    memRead = 1'b0; memWrite = 1'b0; size = 2'b00; loadUnsigned = 1'b0;
    address = '0; writeData = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    n_cmp++; if (readData !== 32'sd0) begin n_err++; $display("FAIL reset_readData: got %h want 00000000", readData); end
    n_cmp++; if (readValid !== 1'b0) begin n_err++; $display("FAIL reset_readValid: got %b want 0", readValid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (misaligned !== 1'b0) begin n_err++; $display("FAIL reset_misaligned: got %b want 0", misaligned); end
  endtask

  task automatic test_word_bytes();
    logic [33:0] act;
    logic [32:0] want;
    drive_store(32'h10, 2'b10, 32'h8070_F00D);
    run_load(32'h13, 2'b00, 1'b0, {1'b0, 32'hFFFF_FF80}, act, want);
    n_cmp++; if (act !== {1'b0, want}) begin n_err++; $display("FAIL byte_signed: got %h want %h", act, {1'b0, want}); end
    run_load(32'h13, 2'b00, 1'b1, {1'b0, 32'h0000_0080}, act, want);
    n_cmp++; if (act !== {1'b0, want}) begin n_err++; $display("FAIL byte_unsigned: got %h want %h", act, {1'b0, want}); end
    run_load(32'h10, 2'b01, 1'b0, {1'b0, 32'hFFFF_F00D}, act, want);
    n_cmp++; if (act !== {1'b0, want}) begin n_err++; $display("FAIL half_low_signed: got %h want %h", act, {1'b0, want}); end
  endtask

  task automatic test_half_merge();
    logic [33:0] act;
    logic [32:0] want;
    drive_store(32'h20, 2'b10, 32'h1122_3344);
    drive_store(32'h22, 2'b01, 32'h0000_BEEF);
    run_load(32'h20, 2'b10, 1'b0, {1'b0, 32'hBEEF_3344}, act, want);
    n_cmp++; if (act !== {1'b0, want}) begin n_err++; $display("FAIL half_merge_word: got %h want %h", act, {1'b0, want}); end
    run_load(32'h22, 2'b01, 1'b0, {1'b0, 32'hFFFF_BEEF}, act, want);
    n_cmp++; if (act !== {1'b0, want}) begin n_err++; $display("FAIL half_merge_signed: got %h want %h", act, {1'b0, want}); end
    run_load(32'h22, 2'b01, 1'b1, {1'b0, 32'h0000_BEEF}, act, want);
    n_cmp++; if (act !== {1'b0, want}) begin n_err++; $display("FAIL half_merge_unsigned: got %h want %h", act, {1'b0, want}); end
  endtask

  task automatic test_misaligned();
    logic [33:0] act;
    logic [32:0] want;
    drive_store(32'h21, 2'b10, 32'hDEAD_BEEF);
    n_cmp++; if (misaligned !== 1'b1) begin n_err++; $display("FAIL mis_store_pulse: got %b want 1", misaligned); end
    tick();
    n_cmp++; if (misaligned !== 1'b0) begin n_err++; $display("FAIL mis_store_once: got %b want 0", misaligned); end
    run_load(32'h20, 2'b10, 1'b0, {1'b0, 32'hBEEF_3344}, act, want);
    n_cmp++; if (act !== {1'b0, want}) begin n_err++; $display("FAIL mis_store_nochange: got %h want %h", act, {1'b0, want}); end
    run_load(32'h23, 2'b01, 1'b0, {1'b1, 32'h0}, act, want);
    n_cmp++; if (act !== {1'b0, want}) begin n_err++; $display("FAIL mis_half_load: got %h want %h", act, {1'b0, want}); end
    run_load(32'h20, 2'b11, 1'b0, {1'b1, 32'h0}, act, want);
    n_cmp++; if (act !== {1'b0, want}) begin n_err++; $display("FAIL illegal_size_load: got %h want %h", act, {1'b0, want}); end
  endtask

  task automatic test_busy_priority();
    logic [33:0] act;
    logic [32:0] want;
    // Issue a load, then hold another load request during RESP.
    memRead = 1'b1; memWrite = 1'b0; size = 2'b10; loadUnsigned = 1'b0; address = 32'h20;
    tick();
    n_cmp++; if ({busy, readValid, readData} !== {2'b11, 32'hBEEF_3344}) begin
      n_err++; $display("FAIL busy_first_resp: got %h want %h", {busy, readValid, readData}, {2'b11, 32'hBEEF_3344});
    end
    address = 32'h10;
    tick();
    memRead = 1'b0;
    n_cmp++; if ({busy, readValid} !== 2'b00) begin n_err++; $display("FAIL busy_ignored_a: got %b want 00", {busy, readValid}); end
    tick();
    n_cmp++; if ({busy, readValid} !== 2'b00) begin n_err++; $display("FAIL busy_ignored_b: got %b want 00", {busy, readValid}); end
    // A simultaneous read and write is handled as a store only.
    memRead = 1'b1; memWrite = 1'b1; size = 2'b10; address = 32'h30; writeData = 32'hCAFE_0001;
    model_store(32'h30, 2'b10, 32'hCAFE_0001);
    tick();
    memRead = 1'b0; memWrite = 1'b0;
    n_cmp++; if ({busy, readValid, misaligned} !== 3'b000) begin n_err++; $display("FAIL prio_no_resp: got %b want 000", {busy, readValid, misaligned}); end
    tick();
    n_cmp++; if (readValid !== 1'b0) begin n_err++; $display("FAIL prio_no_late_resp: got %b want 0", readValid); end
    run_load(32'h30, 2'b10, 1'b0, {1'b0, 32'hCAFE_0001}, act, want);
    n_cmp++; if (act !== {1'b0, want}) begin n_err++; $display("FAIL prio_store_done: got %h want %h", act, {1'b0, want}); end
  endtask

  task automatic test_wrap();
    logic [33:0] act;
    logic [32:0] want;
    drive_store(32'h400, 2'b10, 32'h0000_ABCD);
    run_load(32'h000, 2'b10, 1'b0, {1'b0, 32'h0000_ABCD}, act, want);
    n_cmp++; if (act !== {1'b0, want}) begin n_err++; $display("FAIL wrap_alias: got %h want %h", act, {1'b0, want}); end
  endtask

  task automatic test_reset_mid_load();
    memRead = 1'b1; memWrite = 1'b0; size = 2'b10; address = 32'h30;
    tick();
    memRead = 1'b0;
    reset = 1'b1;
    #1;
    n_cmp++; if (readValid !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid: got %b want 0", readValid); end
    tick();
    reset = 1'b0;
    n_cmp++; if ({busy, readValid, readData} !== 34'h0) begin
      n_err++; $display("FAIL rst_mid_after: got %h want 0", {busy, readValid, readData});
    end
    // The array survives reset.
    drive_store(32'h0, 2'b00, 32'h0000_0000);
  endtask

  task automatic test_back_to_back();
    logic [33:0] act;
    logic [32:0] want;
    logic [31:0] a;
    logic [1:0]  sz;
    logic        exp_mis;
    // Fill words 0x40..0x7C with one store per cycle.
    for (int i = 0; i < 16; i++) begin
      drive_store(32'h40 + 32'(4*i), 2'b10, $urandom);
      n_cmp++; if (misaligned !== 1'b0) begin n_err++; $display("FAIL b2b_fill_mis[%0d]: got %b want 0", i, misaligned); end
    end
    // Random mix of stores and loads within the initialized region.
    for (int i = 0; i < 48; i++) begin
      a  = 32'h40 + 32'($urandom_range(0, 63));
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        exp_mis = is_illegal(a, sz);
        drive_store(a, sz, $urandom);
        n_cmp++; if (misaligned !== exp_mis) begin n_err++; $display("FAIL b2b_store_mis[%0d] a=%h sz=%0d: got %b want %b", i, a, sz, misaligned, exp_mis); end
      end else begin
        loadUnsigned = 1'($urandom_range(0, 1));
        run_load(a, sz, loadUnsigned, model_load(a, sz, loadUnsigned), act, want);
        n_cmp++; if (act !== {1'b0, want}) begin n_err++; $display("FAIL b2b_load[%0d] a=%h sz=%0d: got %h want %h", i, a, sz, act, {1'b0, want}); end
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_word_bytes();
    test_half_merge();
    test_misaligned();
    test_busy_priority();
    test_wrap();
    test_reset_mid_load();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
